// File: rtl/node_stream_feeder.sv
// node_stream_feeder
// Upstream feeder for the center-of-mass (COM) stage. On a frame request it
// walks node memory addresses 0..NUM_NODES-1, forwards each active node's
// (x, y) to the COM inputs once the read data is valid, and pulses
// tabulate_out after the last node. It then waits for com_valid_in before it
// accepts another frame.
//
// Optional feature macro: NODE_MASK_EN
//   defined   : node_mask_in exists and is latched at frame start. Masked
//               nodes are still addressed but are not forwarded.
//               empty_frame_out flags a frame that forwarded no nodes.
//   undefined : every node is active and empty_frame_out is tied to 0.
//
// Ports
//   clk_in            : clock
//   rst_in            : synchronous active-low reset
//   frame_start_in    : one-cycle frame request, honoured only when idle
//   com_valid_in      : COM result valid, ends the frame in WAIT_COM
//   mem_addr_out      : node memory read address
//   mem_x_in/mem_y_in : read data, valid RD_LATENCY cycles after the address
//   node_mask_in      : per-node active bits (NODE_MASK_EN only)
//   x_out/y_out       : registered coordinates to COM
//   valid_out         : coordinate strobe to COM
//   tabulate_out      : one-cycle end-of-stream pulse to COM
//   busy_out          : frame in progress
//   frame_dropped_out : frame_start_in arrived while not idle
//   empty_frame_out   : frame finished with zero forwarded nodes
//
// state      | meaning
// S_IDLE     | waiting for frame_start_in
// S_ISSUE    | driving addresses 0..NUM_NODES-1, one per cycle
// S_DRAIN    | waiting for outstanding reads to come back
// S_TABULATE | one-cycle tabulate_out pulse
// S_WAIT_COM | holding off new frames until com_valid_in

module node_stream_feeder #(
  parameter int POSITION_SIZE = 8,
  parameter int NUM_NODES     = 16,
  parameter int RD_LATENCY    = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         frame_start_in,
  input  logic                         com_valid_in,
  output logic [$clog2(NUM_NODES)-1:0] mem_addr_out,
  input  logic [POSITION_SIZE-1:0]     mem_x_in,
  input  logic [POSITION_SIZE-1:0]     mem_y_in,
`ifdef NODE_MASK_EN
  input  logic [NUM_NODES-1:0]         node_mask_in,
`endif
  output logic [POSITION_SIZE-1:0]     x_out,
  output logic [POSITION_SIZE-1:0]     y_out,
  output logic                         valid_out,
  output logic                         tabulate_out,
  output logic                         busy_out,
  output logic                         frame_dropped_out,
  output logic                         empty_frame_out
);

  localparam int AW = $clog2(NUM_NODES);
  localparam int CW = $clog2(NUM_NODES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_TABULATE,
    S_WAIT_COM
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [AW-1:0]            r_addr;
  logic [CW-1:0]            r_count;
  logic [RD_LATENCY-1:0]    r_tag;
  logic [POSITION_SIZE-1:0] r_x;
  logic [POSITION_SIZE-1:0] r_y;
  logic                     r_valid;
  logic                     w_active;
  logic                     w_tag_in;
  logic                     w_tag_out;
  logic                     w_last_addr;
  logic                     w_drained;

`ifdef NODE_MASK_EN
  logic [NUM_NODES-1:0]     r_mask;
  assign w_active = r_mask[r_addr];
`else
  assign w_active = 1'b1;
`endif

  assign w_last_addr = (r_addr == AW'(NUM_NODES - 1));
  assign w_tag_in    = (r_state == S_ISSUE) && w_active;
  assign w_tag_out   = r_tag[RD_LATENCY-1];
  assign w_drained   = (r_tag == '0);

  // State register plus datapath registers.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_tag   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
`ifdef NODE_MASK_EN
      r_mask  <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      // Tag pipeline mirrors the memory read latency; a tag at the far end
      // means mem_x_in/mem_y_in currently hold an active node's data.
      r_tag   <= (r_tag << 1) | RD_LATENCY'(w_tag_in);

      if (r_state == S_IDLE && frame_start_in) begin
        r_addr  <= '0;
        r_count <= '0;
`ifdef NODE_MASK_EN
        r_mask  <= node_mask_in;
`endif
      end else if (r_state == S_ISSUE && !w_last_addr) begin
        r_addr <= r_addr + 1'b1;
      end

      if (w_tag_out) begin
        r_x     <= mem_x_in;
        r_y     <= mem_y_in;
        r_valid <= 1'b1;
        r_count <= r_count + 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (frame_start_in) w_state_next = S_ISSUE;
      S_ISSUE:    if (w_last_addr) w_state_next = S_DRAIN;
      S_DRAIN:    if (w_drained) w_state_next = (r_count != '0) ? S_TABULATE : S_IDLE;
      S_TABULATE: w_state_next = S_WAIT_COM;
      S_WAIT_COM: if (com_valid_in) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    mem_addr_out      = r_addr;
    x_out             = r_x;
    y_out             = r_y;
    valid_out         = r_valid;
    tabulate_out      = (r_state == S_TABULATE);
    busy_out          = (r_state != S_IDLE);
    frame_dropped_out = frame_start_in && (r_state != S_IDLE);
`ifdef NODE_MASK_EN
    empty_frame_out   = (r_state == S_DRAIN) && w_drained && (r_count == '0);
`else
    empty_frame_out   = 1'b0;
`endif
  end

endmodule

// File: doc/node_stream_feeder.md
# node_stream_feeder

Upstream feeder for the center-of-mass stage. Each frame it walks the node-position memory, streams every active node's (x, y) into the COM block's `x_in`/`y_in`/`valid_in`, then pulses `tabulate_out`. It then holds off the next frame until the COM result (`com_valid_in`) returns, so the COM accumulators are never fed mid-computation.

## Interface
- `POSITION_SIZE`, 8: width of one coordinate, matching COM `POSITION_SIZE`.
- `NUM_NODES`, 16: number of nodes in memory, matching COM `NUM_NODES`; must be ≥ 2.
- `RD_LATENCY`, 2: cycles from `mem_addr_out` change to valid `mem_x_in`/`mem_y_in`; must be ≥ 1.
- `clk_in`, in, 1: single clock.
- `rst_in`, in, 1: synchronous, active-low reset.
- `frame_start_in`, in, 1: one-cycle request to stream one frame.
- `com_valid_in`, in, 1: COM `valid_out`; ends the frame.
- `mem_addr_out`, out, $clog2(NUM_NODES): node memory read address.
- `mem_x_in`, in, POSITION_SIZE: x read data.
- `mem_y_in`, in, POSITION_SIZE: y read data.
- `node_mask_in`, in, NUM_NODES: per-node active bit (only with `NODE_MASK_EN`).
- `x_out`, out, POSITION_SIZE: to COM `x_in`.
- `y_out`, out, POSITION_SIZE: to COM `y_in`.
- `valid_out`, out, 1: to COM `valid_in`.
- `tabulate_out`, out, 1: to COM `tabulate_in`; one-cycle pulse.
- `busy_out`, out, 1: high from first address issue until the frame ends.
- `frame_dropped_out`, out, 1: one-cycle pulse when `frame_start_in` is ignored.
- `empty_frame_out`, out, 1: one-cycle pulse when a frame emitted zero nodes.

## Operation
- Reset (`rst_in`=0 at edge): state IDLE, `mem_addr_out`=0, `x_out`=`y_out`=0, and every 1-bit output is 0. The read pipeline and node count are cleared. A reset mid-frame aborts the frame silently: no `tabulate_out`, no pulse.
- States:
  - IDLE: when `frame_start_in`=1, go to ISSUE. Load address 0, clear the emitted count, latch `node_mask_in`.
  - ISSUE: drive addresses 0..NUM_NODES-1 on consecutive cycles. Push a tag (issued AND active) into a RD_LATENCY-deep shift register. After address NUM_NODES-1, go to DRAIN.
  - DRAIN: wait until the tag pipeline is empty. If the emitted count > 0, go to TABULATE. Otherwise pulse `empty_frame_out` and go to IDLE.
  - TABULATE: `tabulate_out`=1 for exactly one cycle, then go to WAIT_COM.
  - WAIT_COM: on `com_valid_in`=1, go to IDLE.
- Output register: when a tag exits the pipeline, register `mem_x_in`/`mem_y_in` into `x_out`/`y_out`, set `valid_out`=1, and increment the count. Otherwise `valid_out`=0 and `x_out`/`y_out` hold their values.
- Emitted count width is $clog2(NUM_NODES)+1, so NUM_NODES itself is representable.
- `mem_addr_out` holds its last value outside ISSUE. The address never wraps within a frame.
- `frame_start_in` in any state other than IDLE is ignored and pulses `frame_dropped_out` that cycle.
- `com_valid_in` outside WAIT_COM is ignored.
- Zero-node frames never assert `tabulate_out`. The COM stage does not advance with zero mass.

## Timing
- Cycle numbering: `frame_start_in` is sampled high in cycle 0.
- ISSUE: `mem_addr_out`=k in cycle 1+k. `busy_out` goes high in cycle 1.
- Node k data: `valid_out` is high in cycle 2+RD_LATENCY+k.
- Defaults (NUM_NODES=16, RD_LATENCY=2):
  - addresses in cycles 1–16;
  - `valid_out` in cycles 4–19;
  - `tabulate_out` in cycle 20;
  - WAIT_COM from cycle 21.
- Frame end: `com_valid_in` sampled in cycle N puts the block in IDLE in cycle N+1, and `busy_out`=0 in cycle N+1.
- Earliest next `valid_out` is cycle N+1+RD_LATENCY+2. This is at least 2 cycles after the COM reset state.
- `tabulate_out` never coincides with `valid_out`. It occurs exactly one cycle after the last possible `valid_out`.

## Configuration
- `NODE_MASK_EN` defined:
  - the `node_mask_in` port exists and is latched at frame start;
  - nodes with mask bit 0 still get an address but produce no `valid_out`;
  - `empty_frame_out` fires when the latched mask is all-zero.
- `NODE_MASK_EN` undefined:
  - no `node_mask_in` port; all nodes are active;
  - `empty_frame_out` is tied to 0.

## Test plan
- Memory x[k]=k, y[k]=2k, default params, frame start at cycle 0 -> `valid_out` cycles 4–19 with (0,0)…(15,30), `tabulate_out` only in cycle 20, `busy_out` held high.
- Paired with the COM stage, same memory -> COM `valid_out` with x=7, y=15. `com_valid_in` returns the block to IDLE the next cycle.
- `frame_start_in` pulsed in cycle 10 and again in WAIT_COM -> `frame_dropped_out` pulse each time, stream unchanged.
- `rst_in`=0 in cycle 8 for one cycle -> all outputs 0 in cycle 9, no `tabulate_out`, next `frame_start_in` streams normally from address 0.
- With `NODE_MASK_EN` and mask 16'h0005 -> exactly two `valid_out` (nodes 0 and 2, in cycles 4 and 6), `tabulate_out` in cycle 20.
- With `NODE_MASK_EN` and mask 0 -> no `valid_out`, no `tabulate_out`, `empty_frame_out` pulse after the drain, then IDLE.
